button_debounce: RTL and testbench
==================================

# button_debounce

Debounced user-pushbutton input block for the MiniZed board designs: the input-side counterpart of the LED drivers. Samples a raw, asynchronous, bouncing button pin in the on-FPGA oscillator domain and produces a clean level. It also produces one-cycle press/release/long-press event pulses and a running press count, for use by LED-pattern and board-control logic.

## Interface
- DEBOUNCE_CYCLES, 650000 (10 ms at 65 MHz), consecutive stable synchronized samples required to accept a level change; legal range 2 to 2^24.
- LONG_PRESS_CYCLES, 65000000 (1 s at 65 MHz), cycles in PRESSED before a long-press event; must exceed DEBOUNCE_CYCLES.
- ACTIVE_LOW, 0, 1 means the pin reads 0 when pressed; the input is inverted before synchronization.
- clk  input  1  oscillator clock, sole clock.
- rstN  input  1  asynchronous, active-low reset.
- button_in  input  1  raw pin, asynchronous to clk, may bounce.
- button_state  output  1  debounced level, 1 = pressed.
- press  output  1  one-cycle pulse on accepted press.
- release  output  1  one-cycle pulse on accepted release.
- long_press  output  1  one-cycle pulse, at most once per press.
- press_count  output  8  accepted presses modulo 256.

## Operation
- Input path: polarity correction per ACTIVE_LOW, then a 2-flop synchronizer. Flops reset to the not-pressed level.
- FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT. Reset state is IDLE.
- IDLE: synchronized input = 1 -> PRESS_WAIT, stable counter cleared to 1.
- PRESS_WAIT: input = 1 and counter = DEBOUNCE_CYCLES-1 -> PRESSED. Input = 1 otherwise -> counter increments. Input = 0 -> back to IDLE, no event.
- PRESSED: input = 0 -> RELEASE_WAIT, counter set to 1. Otherwise the hold counter increments, saturating at LONG_PRESS_CYCLES.
- RELEASE_WAIT: mirror of PRESS_WAIT with input = 0 accepted. Input = 1 before acceptance -> back to PRESSED. The hold counter is neither cleared nor advanced on this bounce, so no second long_press occurs.
- Entering PRESSED from PRESS_WAIT: press pulses, press_count increments (255 wraps to 0), hold counter cleared.
- Entering IDLE from RELEASE_WAIT: release pulses.
- long_press pulses in the cycle the hold counter reaches LONG_PRESS_CYCLES. Saturation prevents repeats.
- button_state = 1 in PRESSED and RELEASE_WAIT, 0 in IDLE and PRESS_WAIT.
- Counter widths: $clog2(LONG_PRESS_CYCLES+1) for the hold counter, $clog2(DEBOUNCE_CYCLES+1) for the stable counter.

## Timing
- All outputs are registered.
- Reset values: button_state = 0, press = 0, release = 0, long_press = 0, press_count = 0.
- Press latency: the pin is held pressed, cleanly, from before clk edge N. press and button_state rise after edge N+1+DEBOUNCE_CYCLES, i.e. 2 synchronizer cycles plus DEBOUNCE_CYCLES-1 counting cycles plus the output register.
- Release latency: identical to press latency.
- long_press asserts exactly LONG_PRESS_CYCLES cycles after press asserts.
- A single-cycle glitch shorter than DEBOUNCE_CYCLES produces no event.
- A change on the cycle of acceptance (counter = DEBOUNCE_CYCLES-1) cancels the acceptance.
- press and release can never assert in the same cycle.
- rstN asserted mid-press: all outputs clear immediately and asynchronously. After rstN deasserts with the pin still held, a fresh press is reported after the full latency.

## Configuration
- LONG_PRESS_EN defined: hold counter, long_press logic and LONG_PRESS_CYCLES checking are present.
- LONG_PRESS_EN not defined: no hold counter is built, long_press is tied to 0, and LONG_PRESS_CYCLES is ignored. All other behaviour is unchanged.

## Structure
- Package button_pkg holds:
  - typedef enum logic [1:0] button_state_t {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT};
  - the press_count width constant (8).
- Sub-module sync_2ff: a generic 2-flop synchronizer with a reset-value parameter, instantiated once. The FSM and counters stay in button_debounce.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=16, ACTIVE_LOW=0, LONG_PRESS_EN defined.
- Clean press held 10 cycles, then clean release -> press pulse 5 cycles after the input edge; release pulse 5 cycles after the release edge; press_count = 1; no long_press.
- Bounce 1,0,1,0 (one cycle each), then stable 1 -> exactly one press, timed from the start of the stable run; glitches of 3 cycles or fewer produce no event.
- Hold 30 cycles -> one long_press exactly 16 cycles after press; a 2-cycle release bounce mid-hold gives no release and no second long_press.
- 257 clean presses -> press_count wraps to 1.
- rstN pulsed low while PRESSED -> outputs 0 during reset; held pin re-reported as press 5 cycles after rstN release.
- ACTIVE_LOW=1, pin driven 0 -> press; LONG_PRESS_EN undefined -> long_press stays 0 on a 30-cycle hold.

Source files
------------

// File: rtl/button_pkg.sv
// Shared types and constants for the pushbutton debouncer.
// Optional feature macro used by button_debounce: LONG_PRESS_EN.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } button_state_t;

    localparam int PRESS_COUNT_W = 8;

endpackage

// File: rtl/button_debounce_sync_2ff.sv
// Generic two-flop synchronizer for a single-bit asynchronous input.
// RESET_VALUE sets the level both flops take while reset is asserted.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rstN,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops give the first stage a full cycle to resolve.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_debounce.sv
// Debounced pushbutton: synchronizes a raw bouncing pin, accepts a level
// change only after DEBOUNCE_CYCLES stable samples, and emits press,
// release and long-press pulses plus a wrapping press counter.
// Optional feature macro: LONG_PRESS_EN (hold counter and long_press).
// The release event is named release_pulse because release is a
// reserved word in SystemVerilog.
module button_debounce
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 650000,
    parameter int LONG_PRESS_CYCLES = 65000000,
    parameter int ACTIVE_LOW        = 0
) (
    input  logic                     clk,
    input  logic                     rstN,
    input  logic                     button_in,
    output logic                     button_state,
    output logic                     press,
    output logic                     release_pulse,
    output logic                     long_press,
    output logic [PRESS_COUNT_W-1:0] press_count
);

    localparam int SW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [SW-1:0] STABLE_LAST = SW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SW-1:0] STABLE_ONE  = SW'(1);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << 24)) begin : g_bad_debounce
        $error("button_debounce: DEBOUNCE_CYCLES out of range 2..2^24");
    end

    button_state_t state;
    logic [SW-1:0] stable_cnt;
    logic          pin_level;
    logic          sync_in;
    logic          enter_pressed;

    assign pin_level = (ACTIVE_LOW != 0) ? ~button_in : button_in;

    sync_2ff #(
        .RESET_VALUE(1'b0)
    ) u_sync (
        .clk (clk),
        .rstN(rstN),
        .d   (pin_level),
        .q   (sync_in)
    );

    assign enter_pressed = (state == PRESS_WAIT) && sync_in && (stable_cnt == STABLE_LAST);

    // Debounce FSM with registered level, press/release pulses and press counter.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state         <= IDLE;
            stable_cnt    <= '0;
            button_state  <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            press_count   <= '0;
        end else begin
            press         <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (sync_in) begin
                        state      <= PRESS_WAIT;
                        stable_cnt <= STABLE_ONE;
                    end
                end
                PRESS_WAIT: begin
                    if (!sync_in) begin
                        state <= IDLE;
                    end else if (stable_cnt == STABLE_LAST) begin
                        state        <= PRESSED;
                        press        <= 1'b1;
                        button_state <= 1'b1;
                        press_count  <= press_count + PRESS_COUNT_W'(1);
                    end else begin
                        stable_cnt <= stable_cnt + STABLE_ONE;
                    end
                end
                PRESSED: begin
                    if (!sync_in) begin
                        state      <= RELEASE_WAIT;
                        stable_cnt <= STABLE_ONE;
                    end
                end
                RELEASE_WAIT: begin
                    if (sync_in) begin
                        state <= PRESSED;
                    end else if (stable_cnt == STABLE_LAST) begin
                        state         <= IDLE;
                        release_pulse <= 1'b1;
                        button_state  <= 1'b0;
                    end else begin
                        stable_cnt <= stable_cnt + STABLE_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef LONG_PRESS_EN
    localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

    if (LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long_press
        $error("button_debounce: LONG_PRESS_CYCLES must exceed DEBOUNCE_CYCLES");
    end

    logic [HW-1:0] hold_cnt;

    // Hold counter runs only while pressed and stable; saturation makes long_press one-shot.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            hold_cnt   <= '0;
            long_press <= 1'b0;
        end else begin
            long_press <= 1'b0;
            if (enter_pressed) begin
                hold_cnt <= '0;
            end else if ((state == PRESSED) && sync_in && (hold_cnt != HOLD_MAX)) begin
                hold_cnt <= hold_cnt + HW'(1);
                if (hold_cnt == HOLD_LAST) begin
                    long_press <= 1'b1;
                end
            end
        end
    end
`else
    logic unused_cfg;
    logic unused_enter;

    assign unused_cfg   = ^LONG_PRESS_CYCLES;
    assign unused_enter = enter_pressed;
    assign long_press   = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Directed self-checking bench for button_debounce with DEBOUNCE_CYCLES=4,
// LONG_PRESS_CYCLES=16. A second instance exercises ACTIVE_LOW=1.
// Long-press expectations follow whether LONG_PRESS_EN is defined.
module tb_button_debounce;

    localparam int DC = 4;
    localparam int LP = 16;
`ifdef LONG_PRESS_EN
    localparam bit LP_EN = 1'b1;
`else
    localparam bit LP_EN = 1'b0;
`endif
    localparam int LONG_HIT = LP_EN ? (6 + LP) : 0;

    logic       clk;
    logic       rstN;
    logic       button_in;
    logic       button_state;
    logic       press;
    logic       release_pulse;
    logic       long_press;
    logic [7:0] press_count;

    logic       pin_n;
    logic       button_state2;
    logic       press2;
    logic       release2;
    logic       long_press2;
    logic [7:0] press_count2;

    int n_cmp = 0;
    int n_bad = 0;

    button_debounce #(
        .DEBOUNCE_CYCLES  (DC),
        .LONG_PRESS_CYCLES(LP),
        .ACTIVE_LOW       (0)
    ) dut (
        .clk          (clk),
        .rstN         (rstN),
        .button_in    (button_in),
        .button_state (button_state),
        .press        (press),
        .release_pulse(release_pulse),
        .long_press   (long_press),
        .press_count  (press_count)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES  (DC),
        .LONG_PRESS_CYCLES(LP),
        .ACTIVE_LOW       (1)
    ) dut_low (
        .clk          (clk),
        .rstN         (rstN),
        .button_in    (pin_n),
        .button_state (button_state2),
        .press        (press2),
        .release_pulse(release2),
        .long_press   (long_press2),
        .press_count  (press_count2)
    );

    // Free-running 100 MHz bench clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        assert (actual === expected)
        else begin
            n_bad++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic level, input int cycles);
        button_in = level;
        repeat (cycles) step();
    endtask

    // Steps n edges after the current drive; each event must fire only at its hit edge (0 = never).
    task automatic watchEvents(input string tag, input int n, input int hp, input int hr, input int hl);
        for (int k = 1; k <= n; k++) begin
            step();
            checkOutput($sformatf("%s press k=%0d", tag, k), {31'd0, press}, {31'd0, k == hp});
            checkOutput($sformatf("%s release k=%0d", tag, k), {31'd0, release_pulse}, {31'd0, k == hr});
            checkOutput($sformatf("%s long k=%0d", tag, k), {31'd0, long_press}, {31'd0, k == hl});
        end
    endtask

    // Linear directed sequence.
    initial begin
        rstN      = 1'b0;
        button_in = 1'b0;
        pin_n     = 1'b1;
        repeat (3) step();
        checkOutput("reset state", {31'd0, button_state}, 32'd0);
        checkOutput("reset press", {31'd0, press}, 32'd0);
        checkOutput("reset release", {31'd0, release_pulse}, 32'd0);
        checkOutput("reset long", {31'd0, long_press}, 32'd0);
        checkOutput("reset count", {24'd0, press_count}, 32'd0);
        checkOutput("reset state low", {31'd0, button_state2}, 32'd0);
        rstN = 1'b1;
        repeat (3) step();
        checkOutput("idle state", {31'd0, button_state}, 32'd0);

        $display("[TB] clean press and release");
        button_in = 1'b1;
        watchEvents("clean press", 8, 6, 0, 0);
        checkOutput("clean state high", {31'd0, button_state}, 32'd1);
        checkOutput("clean count", {24'd0, press_count}, 32'd1);
        applyStimulus(1'b1, 2);
        button_in = 1'b0;
        watchEvents("clean release", 8, 0, 6, 0);
        checkOutput("clean state low", {31'd0, button_state}, 32'd0);

        $display("[TB] bounce then stable");
        applyStimulus(1'b1, 1);
        applyStimulus(1'b0, 1);
        applyStimulus(1'b1, 1);
        applyStimulus(1'b0, 1);
        button_in = 1'b1;
        watchEvents("bounce press", 10, 6, 0, 0);
        checkOutput("bounce count", {24'd0, press_count}, 32'd2);
        button_in = 1'b0;
        watchEvents("bounce release", 8, 0, 6, 0);

        $display("[TB] long hold with release bounce");
        button_in = 1'b1;
        watchEvents("hold", 24, 6, 0, LONG_HIT);
        applyStimulus(1'b0, 2);
        button_in = 1'b1;
        watchEvents("hold bounce", 20, 0, 0, 0);
        checkOutput("hold state", {31'd0, button_state}, 32'd1);
        checkOutput("hold count", {24'd0, press_count}, 32'd3);
        button_in = 1'b0;
        watchEvents("hold release", 8, 0, 6, 0);

        $display("[TB] 3-cycle glitch");
        applyStimulus(1'b1, 3);
        button_in = 1'b0;
        watchEvents("glitch", 10, 0, 0, 0);
        checkOutput("glitch state", {31'd0, button_state}, 32'd0);
        checkOutput("glitch count", {24'd0, press_count}, 32'd3);

        $display("[TB] active-low instance");
        pin_n = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            checkOutput($sformatf("low press k=%0d", k), {31'd0, press2}, {31'd0, k == 6});
            checkOutput($sformatf("low long k=%0d", k), {31'd0, long_press2}, 32'd0);
        end
        checkOutput("low state", {31'd0, button_state2}, 32'd1);
        checkOutput("low count", {24'd0, press_count2}, 32'd1);
        pin_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            checkOutput($sformatf("low release k=%0d", k), {31'd0, release2}, {31'd0, k == 6});
        end
        checkOutput("low state off", {31'd0, button_state2}, 32'd0);

        $display("[TB] press counter wrap");
        #3 rstN = 1'b0;
        step();
        rstN = 1'b1;
        repeat (3) step();
        for (int i = 1; i <= 257; i++) begin
            applyStimulus(1'b1, 7);
            applyStimulus(1'b0, 7);
            checkOutput($sformatf("wrap count i=%0d", i), {24'd0, press_count}, i % 256);
        end

        $display("[TB] reset while pressed");
        button_in = 1'b1;
        watchEvents("pre-reset press", 8, 6, 0, 0);
        checkOutput("pre-reset state", {31'd0, button_state}, 32'd1);
        #3 rstN = 1'b0;
        #1;
        checkOutput("async reset state", {31'd0, button_state}, 32'd0);
        checkOutput("async reset count", {24'd0, press_count}, 32'd0);
        step();
        checkOutput("held reset state", {31'd0, button_state}, 32'd0);
        checkOutput("held reset press", {31'd0, press}, 32'd0);
        rstN = 1'b1;
        watchEvents("post-reset press", 8, 6, 0, 0);
        checkOutput("post-reset count", {24'd0, press_count}, 32'd1);
        checkOutput("post-reset state", {31'd0, button_state}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
